// File: rtl/evaluate_pawn_structure.sv
// Two-lane pawn-structure evaluator: isolated, doubled and passed terms, white minus black.
// Optional macro EVAL_PAWNS_PASSED_BLOCKED_EN halves the passed bonus when the square ahead is occupied.
//
// state      | meaning
// S_IDLE     | waiting for a board_valid rising edge
// S_LATENCY  | pipeline in flight, down-counter to the output edge
// S_WAIT_CLEAR | result held on eval_mg/eval_eg until clear_eval

`ifndef PIECE_WIDTH
`define PIECE_WIDTH 4
`endif
`ifndef BOARD_WIDTH
`define BOARD_WIDTH (64*`PIECE_WIDTH)
`endif

module evaluate_pawn_structure #(
    parameter int EVAL_WIDTH      = 24,
    parameter int DOUBLED_NEAREST = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         board_valid,
    input  logic [`BOARD_WIDTH-1:0]      board,
    input  logic                         clear_eval,
    output logic signed [EVAL_WIDTH-1:0] eval_mg,
    output logic signed [EVAL_WIDTH-1:0] eval_eg,
    output logic                         eval_valid,
    output logic                         busy
);

    // Piece code: MSB is colour (1 = black), low three bits are the type (0 = empty, 1 = pawn).
    localparam logic [2:0] PT_PAWN = 3'd1;

    localparam int ISO_MG [8]    = '{default: -10};
    localparam int ISO_EG [8]    = '{default: -20};
    localparam int DBL_MG [8][8] = '{default: '{default: -15}};
    localparam int DBL_EG [8][8] = '{default: '{default: -30}};
    localparam int PAS_MG [8]    = '{0, 10, 20, 30, 40, 50, 60, 70};
    localparam int PAS_EG [8]    = '{0, 20, 40, 60, 80, 100, 120, 140};

    typedef enum logic [1:0] {S_IDLE, S_LATENCY, S_WAIT_CLEAR} state_t;

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_cnt, w_cnt_nxt;
    logic                    r_valid, w_valid_nxt, r_bv_d, w_start, w_load;
    logic signed [EVAL_WIDTH-1:0] r_mg, r_eg, r_diff_mg, r_diff_eg;
    logic [63:0]             w_wp, w_bp, w_wp_f, w_bp_f;
`ifdef EVAL_PAWNS_PASSED_BLOCKED_EN
    logic [63:0]             w_any, w_any_f;
`endif

    function automatic logic [5:0] sq6(input int r, input int c);
        return 6'(r * 8 + c);
    endfunction

    function automatic logic col_hit(input logic [63:0] m, input int c, input int row_lo);
        logic hit;
        hit = 1'b0;
        if (c >= 0 && c < 8)
            for (int rr = 1; rr < 7; rr++)
                if (rr >= row_lo && m[sq6(rr, c)]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic is_passed(input logic [63:0] enm, input int r, input int c);
        return !col_hit(enm, c - 1, r + 1) && !col_hit(enm, c, r + 1) && !col_hit(enm, c + 1, r + 1);
    endfunction

    function automatic logic [2:0] dbl_dist(input logic [63:0] m, input int r, input int c);
        logic [2:0] d;
        d = 3'd0;
        for (int k = 1; k <= 5; k++)
            if (r + k < 7 && m[sq6(r + k, c)] && (DOUBLED_NEAREST == 0 || d == 3'd0)) d = 3'(k);
        return d;
    endfunction

    // pas: 0 = not passed, 1 = passed but blocked (half bonus), 2 = full bonus
    function automatic logic signed [EVAL_WIDTH-1:0] sq_weight(input logic iso, input logic [2:0] dd,
            input logic [1:0] pas, input logic [2:0] r, input logic [2:0] c, input logic eg);
        logic signed [EVAL_WIDTH-1:0] w, p;
        w = '0;
        if (iso) w = w + EVAL_WIDTH'(eg ? ISO_EG[c] : ISO_MG[c]);
        if (dd != 3'd0) w = w + EVAL_WIDTH'(eg ? DBL_EG[c][dd] : DBL_MG[c][dd]);
        p = EVAL_WIDTH'(eg ? PAS_EG[r] : PAS_MG[r]);
        if (pas == 2'd2) w = w + p;
        else if (pas == 2'd1) w = w + (p >>> 1);
        return w;
    endfunction

    // Raw pawn masks plus row-flipped copies so the black lane sees white geometry.
    for (genvar g = 0; g < 64; g++) begin : g_sq
        localparam int ROW = g / 8;
        localparam int FG  = (7 - ROW) * 8 + g % 8;
        logic [`PIECE_WIDTH-1:0] w_pc;
        assign w_pc      = board[g*`PIECE_WIDTH +: `PIECE_WIDTH];
        assign w_wp[g]   = (ROW > 0) && (ROW < 7) && (w_pc[2:0] == PT_PAWN) && !w_pc[`PIECE_WIDTH-1];
        assign w_bp[g]   = (ROW > 0) && (ROW < 7) && (w_pc[2:0] == PT_PAWN) && w_pc[`PIECE_WIDTH-1];
        assign w_wp_f[FG] = w_wp[g];
        assign w_bp_f[FG] = w_bp[g];
`ifdef EVAL_PAWNS_PASSED_BLOCKED_EN
        assign w_any[g]   = (w_pc[2:0] != 3'd0);
        assign w_any_f[FG] = w_any[g];
`endif
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [63:0] r_own, r_enm, r_iso;
`ifdef EVAL_PAWNS_PASSED_BLOCKED_EN
        logic [63:0] r_occ;
`endif
        logic [2:0] r_dd [64];
        logic [1:0] r_pas [64];
        logic signed [EVAL_WIDTH-1:0] r_wmg [64], r_weg [64];
        logic signed [EVAL_WIDTH-1:0] r_s16_mg [16], r_s16_eg [16], r_s4_mg [4], r_s4_eg [4];
        logic signed [EVAL_WIDTH-1:0] r_s1_mg, r_s1_eg;

        always_ff @(posedge clk) begin
            if (w_start) begin
                r_own <= (l == 0) ? w_wp : w_bp_f;
                r_enm <= (l == 0) ? w_bp : w_wp_f;
`ifdef EVAL_PAWNS_PASSED_BLOCKED_EN
                r_occ <= (l == 0) ? w_any : w_any_f;
`endif
            end
        end

        always_ff @(posedge clk) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_iso[sq6(r, c)] <= r_own[sq6(r, c)] && !col_hit(r_own, c - 1, 1) && !col_hit(r_own, c + 1, 1);
                    r_dd[sq6(r, c)]  <= r_own[sq6(r, c)] ? dbl_dist(r_own, r, c) : 3'd0;
`ifdef EVAL_PAWNS_PASSED_BLOCKED_EN
                    r_pas[sq6(r, c)] <= !(r_own[sq6(r, c)] && is_passed(r_enm, r, c)) ? 2'd0 :
                                        (r < 7 && r_occ[sq6(r + 1, c)]) ? 2'd1 : 2'd2;
`else
                    r_pas[sq6(r, c)] <= (r_own[sq6(r, c)] && is_passed(r_enm, r, c)) ? 2'd2 : 2'd0;
`endif
                    r_wmg[sq6(r, c)] <= sq_weight(r_iso[sq6(r, c)], r_dd[sq6(r, c)], r_pas[sq6(r, c)],
                                                  3'(r), 3'(c), 1'b0);
                    r_weg[sq6(r, c)] <= sq_weight(r_iso[sq6(r, c)], r_dd[sq6(r, c)], r_pas[sq6(r, c)],
                                                  3'(r), 3'(c), 1'b1);
                end
            end
            for (int i = 0; i < 16; i++) begin
                r_s16_mg[4'(i)] <= r_wmg[6'(4*i)] + r_wmg[6'(4*i+1)] + r_wmg[6'(4*i+2)] + r_wmg[6'(4*i+3)];
                r_s16_eg[4'(i)] <= r_weg[6'(4*i)] + r_weg[6'(4*i+1)] + r_weg[6'(4*i+2)] + r_weg[6'(4*i+3)];
            end
            for (int i = 0; i < 4; i++) begin
                r_s4_mg[2'(i)] <= r_s16_mg[4'(4*i)] + r_s16_mg[4'(4*i+1)] + r_s16_mg[4'(4*i+2)] + r_s16_mg[4'(4*i+3)];
                r_s4_eg[2'(i)] <= r_s16_eg[4'(4*i)] + r_s16_eg[4'(4*i+1)] + r_s16_eg[4'(4*i+2)] + r_s16_eg[4'(4*i+3)];
            end
            r_s1_mg <= r_s4_mg[0] + r_s4_mg[1] + r_s4_mg[2] + r_s4_mg[3];
            r_s1_eg <= r_s4_eg[0] + r_s4_eg[1] + r_s4_eg[2] + r_s4_eg[3];
        end
    end

    always_ff @(posedge clk) begin
        r_diff_mg <= g_lane[0].r_s1_mg - g_lane[1].r_s1_mg;
        r_diff_eg <= g_lane[0].r_s1_eg - g_lane[1].r_s1_eg;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_start     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (board_valid && !r_bv_d) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_LATENCY;
                    w_cnt_nxt   = 3'd7;
                end
            end
            S_LATENCY: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = S_WAIT_CLEAR;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_WAIT_CLEAR: begin
                if (clear_eval) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_valid <= 1'b0;
            r_bv_d  <= 1'b0;
            r_mg    <= '0;
            r_eg    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_bv_d  <= board_valid;
            if (w_load) begin
                r_mg <= r_diff_mg;
                r_eg <= r_diff_eg;
            end
        end
    end

    assign eval_mg    = r_mg;
    assign eval_eg    = r_eg;
    assign eval_valid = r_valid;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_evaluate_pawn_structure.sv
// Scoreboard bench for evaluate_pawn_structure: directed boards, monitor checks each eval_valid rise.
`ifndef PIECE_WIDTH
`define PIECE_WIDTH 4
`endif
`ifndef BOARD_WIDTH
`define BOARD_WIDTH (64*`PIECE_WIDTH)
`endif

module tb_evaluate_pawn_structure;
    localparam int EW = 24;
    localparam logic [3:0] WP = 4'h1, BP = 4'h9, BN = 4'hA;

    logic clk = 1'b0, reset = 1'b1, board_valid = 1'b0, clear_eval = 1'b0;
    logic [`BOARD_WIDTH-1:0] board = '0;
    logic signed [EW-1:0] eval_mg, eval_eg;
    logic eval_valid, busy;

    evaluate_pawn_structure #(.EVAL_WIDTH(EW), .DOUBLED_NEAREST(1)) dut (
        .clk(clk), .reset(reset), .board_valid(board_valid), .board(board),
        .clear_eval(clear_eval), .eval_mg(eval_mg), .eval_eg(eval_eg),
        .eval_valid(eval_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { string name; int mg; int eg; int due; } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [`BOARD_WIDTH-1:0] place(input logic [`BOARD_WIDTH-1:0] b, input int sq,
                                                      input logic [3:0] p);
        b[sq*4 +: 4] = p;
        return b;
    endfunction

    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (eval_valid && !prev_v) begin
            if (sb.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                e = sb.pop_front();
                check({e.name, "_mg"}, int'(eval_mg), e.mg);
                check({e.name, "_eg"}, int'(eval_eg), e.eg);
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
        prev_v = eval_valid;
    end

    task automatic start(input logic [`BOARD_WIDTH-1:0] b, input string name, input int mg, input int eg);
        @(negedge clk);
        board = b;
        board_valid = 1'b1;
        sb.push_back('{name, mg, eg, cyc + 9});
        @(negedge clk);
        board_valid = 1'b0;
        check({name, "_busy"}, int'(busy), 1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!eval_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_seen"}, int'(eval_valid), 1);
    endtask

    task automatic clear_it(input string name);
        @(negedge clk);
        clear_eval = 1'b1;
        @(negedge clk);
        clear_eval = 1'b0;
        check({name, "_cleared_valid"}, int'(eval_valid), 0);
        check({name, "_cleared_busy"}, int'(busy), 0);
    endtask

    task automatic run(input logic [`BOARD_WIDTH-1:0] b, input string name, input int mg, input int eg);
        start(b, name, mg, eg);
        wait_valid(name);
        clear_it(name);
    endtask

    logic [`BOARD_WIDTH-1:0] b1, b2, b3, b6;

    initial begin
        b1 = place('0, 12, WP);
        b2 = place(place(place('0, 8, WP), 24, WP), 49, BP);
        b3 = place(place(place('0, 48, BP), 32, BP), 9, WP);
        b6 = place(place('0, 35, WP), 43, BN);

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", int'(eval_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_mg", int'(eval_mg), 0);
        check("reset_eg", int'(eval_eg), 0);
        reset = 1'b1;
        @(negedge clk);

        run(b1, "lone_e2", 0, 0);
        run('0, "empty", 0, 0);
        run(b2, "white_doubled", -25, -50);
        run(b3, "black_mirror", 25, 50);

        // restart and clear during LATENCY must both be ignored
        start(b2, "ignore_in_flight", -25, -50);
        @(negedge clk);
        board = b3;
        board_valid = 1'b1;
        @(negedge clk);
        clear_eval = 1'b1;
        @(negedge clk);
        clear_eval = 1'b0;
        check("early_clear_busy", int'(busy), 1);
        check("early_clear_valid", int'(eval_valid), 0);
        wait_valid("ignore_in_flight");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            board_valid = ~board_valid;
            board = place(board, 20 + i, WP);
            check("frozen_valid", int'(eval_valid), 1);
            check("frozen_mg", int'(eval_mg), -25);
            check("frozen_eg", int'(eval_eg), -50);
        end
        board_valid = 1'b0;
        clear_it("ignore_in_flight");

        // asynchronous reset in the middle of an evaluation
        @(negedge clk);
        board = b2;
        board_valid = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 check("pre_reset_busy", int'(busy), 1);
        #1 reset = 1'b0;
        #1;
        check("async_reset_valid", int'(eval_valid), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_mg", int'(eval_mg), 0);
        check("async_reset_eg", int'(eval_eg), 0);
        @(negedge clk);
        board_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run(b3, "post_reset", 25, 50);

`ifdef EVAL_PAWNS_PASSED_BLOCKED_EN
        run(b6, "blocked_passer", 10, 20);
`else
        run(b6, "blocked_passer", 30, 60);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/evaluate_pawn_structure.md
Name: evaluate_pawn_structure

Overview:
Successor pawn-structure evaluator for the eval pipeline. It scores both colours in one pass instead of only the side not to move. It adds a passed-pawn term to the existing isolated and doubled terms. It returns white-minus-black midgame and endgame scores under the same board_valid / eval_valid / clear_eval handshake used by the other evaluate_* blocks.

Parameters:
EVAL_WIDTH, 24, signed width of all score accumulators and outputs; all intermediate sums are sign-extended to EVAL_WIDTH and wrap modulo 2^EVAL_WIDTH (no saturation).
DOUBLED_NEAREST, 1, 1: doubled distance is the nearest own pawn ahead; 0: the farthest own pawn ahead.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
board_valid  input  1  board stable; a rising edge starts an evaluation
board  input  `BOARD_WIDTH  64 squares x `PIECE_WIDTH, square index = row*8+col
clear_eval  input  1  consumer has taken the result; return to idle
eval_mg  output  EVAL_WIDTH  signed midgame score, white minus black
eval_eg  output  EVAL_WIDTH  signed endgame score, white minus black
eval_valid  output  1  eval_mg/eval_eg valid and held
busy  output  1  evaluation in flight or awaiting clear

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; eval_valid=0, busy=0, eval_mg=0, eval_eg=0. Pipeline registers need not reset. Deassertion takes effect on the next clk edge.
- Start condition: board_valid high with board_valid registered low one cycle earlier, while in IDLE. board is sampled on that edge (t1). Board changes afterwards do not affect the result.
- Rows 0 and 7 are never treated as pawn squares.
- Normalisation: black board rows are flipped (7-r) so both colours use white geometry. Two identical evaluation lanes run in parallel.
- Per lane, per pawn at normalised (r,c):
  - isolated: no own pawn on column c-1 or c+1; edge columns check one neighbour only. Adds iso_mg[c] / iso_eg[c].
  - doubled: an own pawn exists at row r' > r on column c. d = r'-r (1..5), nearest or farthest per DOUBLED_NEAREST. Adds dbl_mg[c][d] / dbl_eg[c][d].
  - passed: no enemy pawn on columns c-1..c+1 at any row > r in this lane's normalised frame. Adds pas_mg[r] / pas_eg[r].
- Pipeline: t1 capture/flip; t2 per-square flags and doubled distance; t3 weight lookup; t4 64->16 adder tree; t5 16->4; t6 4->1 per lane; t7 white minus black; t8 output register.
- Latency: eval_valid rises exactly 8 clk edges after the start edge. busy is high from the cycle after the start edge until the cycle after clear_eval is accepted.
- FSM:
  - IDLE -> LATENCY on a start condition.
  - LATENCY counts 1..7, then -> WAIT_CLEAR with eval_valid<=1.
  - WAIT_CLEAR -> IDLE on clear_eval, with eval_valid<=0 the same edge.
  - Illegal state -> IDLE.
- Boundaries:
  - Rising edges of board_valid outside IDLE are ignored. No queueing; a new evaluation needs a fresh rising edge after return to IDLE.
  - clear_eval in IDLE or LATENCY is ignored.
  - clear_eval coinciding with a start condition in WAIT_CLEAR: the clear is honoured and the start is dropped.
  - eval_mg/eval_eg are frozen while eval_valid=1.
  - Empty board gives 0/0.
- Weight tables (iso_*, dbl_*, pas_*) are initialised from evaluate_pawn_structure.vh.

Optional Feature:
EVAL_PAWNS_PASSED_BLOCKED_EN
- Defined: a passed pawn whose square directly ahead (normalised r+1) holds any piece scores pas_mg[r]>>>1 and pas_eg[r]>>>1 (arithmetic shift).
- Undefined: occupancy ahead is ignored and the full passed bonus applies.
- Latency is unchanged either way.

Test Plan:
Bench uses a test include with iso_mg=-10, iso_eg=-20, dbl_mg=-15, dbl_eg=-30 for all c,d, pas_mg[r]=10*r, pas_eg[r]=20*r.
1. Lone white pawn e2, no black pawns, start -> eval_valid at edge 8. Isolated -10/-20 plus passed r=1 +10/+20 gives eval_mg=0, eval_eg=0. busy high during the run.
2. White pawns a2,a4, black pawn b7 -> no white pawn is passed and black's pawn is not passed. Doubled a2 (d=2) plus isolated a2,a4 gives mg=-35, eg=-70; black isolated b7 gives mg+10, eg+20. Result eval_mg=-25, eval_eg=-50.
3. Mirror of scenario 2 (black a7,a5; white b2) -> eval_mg=+25, eval_eg=+50, confirming colour symmetry.
4. Second board_valid rising edge during LATENCY and clear_eval pulsed at edge 4 -> both ignored; result equals the first board; eval_valid stays 1 until the next clear_eval.
5. reset driven low at edge 5 of an evaluation -> eval_valid, busy, and outputs go 0 asynchronously. After release, a fresh start completes in 8 edges.
6. With EVAL_PAWNS_PASSED_BLOCKED_EN: white d5 with a black knight on d6, no other pawns -> isolated -10/-20 plus halved passed (r=4) +20/+40 gives eval_mg=+10, eval_eg=+20. Without the macro: eval_mg=+30, eval_eg=+60.
